// File: rtl/qpsk_symbol_framer.sv
// QPSK symbol framer: byte FIFO feeding preamble / SFD / payload dibits to the modulator.
// Build macro QPSK_PREAMBLE_EN adds the alternating-phase preamble ahead of each SFD.
module qpsk_symbol_framer #(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter logic [7:0]  SFD_BYTE     = 8'hD5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          mod_req,
   output logic [1:0]                    symbol_out,
   output logic                          symbol_en,
   output logic                          busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
`ifdef QPSK_PREAMBLE_EN
   localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
`endif

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PREAMBLE_LEN < 1) begin : g_bad_param
      $error("qpsk_symbol_framer: illegal FIFO_DEPTH or PREAMBLE_LEN");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
`ifdef QPSK_PREAMBLE_EN
      PREAMBLE = 2'd1,
`endif
      SFD      = 2'd2,
      PAYLOAD  = 2'd3
   } state_t;

   state_t            state;
   logic [1:0]        dibit_idx;
   logic [7:0]        shreg;
`ifdef QPSK_PREAMBLE_EN
   logic [PRE_W-1:0]  pre_cnt;
`endif

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [7:0]        rd_data;

   assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign empty   = (fifo_level == '0);
   assign s_ready = !full;
   assign push    = s_valid && !full;
   assign pop     = mod_req && (state == PAYLOAD) && (dibit_idx == 2'd0) && !empty;
   assign rd_data = mem[rd_ptr];

   function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
      case (idx)
         2'd0:    dibit_of = b[7:6];
         2'd1:    dibit_of = b[5:4];
         2'd2:    dibit_of = b[3:2];
         default: dibit_of = b[1:0];
      endcase
   endfunction

   // Storage array carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Framing FSM; advances only on modulator requests, frame_done self-clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         dibit_idx  <= 2'd0;
         shreg      <= 8'h00;
         symbol_out <= 2'b00;
         symbol_en  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
`ifdef QPSK_PREAMBLE_EN
         pre_cnt    <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (mod_req) begin
            case (state)
               IDLE: begin
                  if (!empty) begin
                     busy      <= 1'b1;
                     symbol_en <= 1'b1;
`ifdef QPSK_PREAMBLE_EN
                     state      <= PREAMBLE;
                     symbol_out <= 2'b00;
                     pre_cnt    <= PRE_W'(1);
`else
                     state      <= SFD;
                     symbol_out <= dibit_of(SFD_BYTE, 2'd0);
                     dibit_idx  <= 2'd1;
`endif
                  end else begin
                     symbol_en  <= 1'b0;
                     symbol_out <= 2'b00;
                  end
               end
`ifdef QPSK_PREAMBLE_EN
               PREAMBLE: begin
                  if (pre_cnt == PRE_W'(PREAMBLE_LEN)) begin
                     state      <= SFD;
                     symbol_out <= dibit_of(SFD_BYTE, 2'd0);
                     dibit_idx  <= 2'd1;
                  end else begin
                     symbol_out <= {pre_cnt[0], 1'b0};
                     pre_cnt    <= pre_cnt + PRE_W'(1);
                  end
               end
`endif
               SFD: begin
                  symbol_out <= dibit_of(SFD_BYTE, dibit_idx);
                  dibit_idx  <= dibit_idx + 2'd1;
                  if (dibit_idx == 2'd3) state <= PAYLOAD;
               end
               PAYLOAD: begin
                  if (dibit_idx == 2'd0) begin
                     if (!empty) begin
                        shreg      <= rd_data;
                        symbol_out <= dibit_of(rd_data, 2'd0);
                        dibit_idx  <= 2'd1;
                     end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        symbol_en  <= 1'b0;
                        symbol_out <= 2'b00;
                        frame_done <= 1'b1;
                     end
                  end else begin
                     symbol_out <= dibit_of(shreg, dibit_idx);
                     dibit_idx  <= dibit_idx + 2'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Directed bench for qpsk_symbol_framer (FIFO_DEPTH=4, PREAMBLE_LEN=4), either macro setting.
module tb_qpsk_symbol_framer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       mod_req;
   logic [1:0] symbol_out;
   logic       symbol_en;
   logic       busy;
   logic       frame_done;
   logic [2:0] fifo_level;

   int total = 0;
   int bad   = 0;
   logic [7:0] feed_q[$];

   always #5 clk = ~clk;

   qpsk_symbol_framer #(.FIFO_DEPTH(4), .PREAMBLE_LEN(4), .SFD_BYTE(8'hD5)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .mod_req(mod_req), .symbol_out(symbol_out), .symbol_en(symbol_en), .busy(busy),
      .frame_done(frame_done), .fifo_level(fifo_level)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; retires the head of the feed queue if it was accepted on this edge.
   task automatic tick();
      logic acc;
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) void'(feed_q.pop_front());
      if (feed_q.size() > 0) begin
         s_valid = 1'b1;
         s_data  = feed_q[0];
      end else begin
         s_valid = 1'b0;
      end
   endtask

   task automatic push(input logic [7:0] b);
      feed_q.push_back(b);
      s_valid = 1'b1;
      s_data  = feed_q[0];
   endtask

   task automatic req(input string tag, input logic [1:0] sym, input logic en);
      mod_req = 1'b1;
      tick();
      mod_req = 1'b0;
      chk({tag, ".sym"}, 8'(symbol_out), 8'(sym));
      chk({tag, ".en"}, 8'(symbol_en), 8'(en));
      chk({tag, ".busy"}, 8'(busy), 8'(en));
      chk({tag, ".fd"}, 8'(frame_done), 8'h00);
   endtask

   task automatic req_end(input string tag);
      mod_req = 1'b1;
      tick();
      mod_req = 1'b0;
      chk({tag, ".end_en"}, 8'(symbol_en), 8'h00);
      chk({tag, ".end_sym"}, 8'(symbol_out), 8'h00);
      chk({tag, ".end_fd"}, 8'(frame_done), 8'h01);
      chk({tag, ".end_busy"}, 8'(busy), 8'h00);
      tick();
      chk({tag, ".fd_clear"}, 8'(frame_done), 8'h00);
   endtask

   task automatic preamble(input string tag);
`ifdef QPSK_PREAMBLE_EN
      for (int i = 0; i < 4; i++) req({tag, ".pre"}, (i % 2 == 1) ? 2'b10 : 2'b00, 1'b1);
`else
      chk({tag, ".no_pre_busy"}, 8'(busy), 8'h00);
`endif
   endtask

   task automatic sfd(input string tag);
      req({tag, ".sfd0"}, 2'b11, 1'b1);
      req({tag, ".sfd1"}, 2'b01, 1'b1);
      req({tag, ".sfd2"}, 2'b01, 1'b1);
      req({tag, ".sfd3"}, 2'b01, 1'b1);
   endtask

   task automatic payload_byte(input string tag, input logic [7:0] b, input int first);
      logic [7:0] t;
      for (int i = first; i < 4; i++) begin
         t = b >> (6 - 2 * i);
         req(tag, t[1:0], 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      s_data  = 8'h00;
      s_valid = 1'b0;
      mod_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst.s_ready", 8'(s_ready), 8'h01);
      chk("rst.level", 8'(fifo_level), 8'h00);
      chk("rst.fd", 8'(frame_done), 8'h00);
      for (int i = 0; i < 5; i++) req("rst.idle", 2'b00, 1'b0);
      chk("rst.s_ready2", 8'(s_ready), 8'h01);

      // Single byte 1B: dibits 00 01 10 11
      push(8'h1B);
      tick();
      chk("b1b.level", 8'(fifo_level), 8'h01);
      preamble("b1b");
      sfd("b1b");
      req("b1b.d0", 2'b00, 1'b1);
      req("b1b.d1", 2'b01, 1'b1);
      tick();
      tick();
      chk("b1b.hold_sym", 8'(symbol_out), 8'h01);
      chk("b1b.hold_en", 8'(symbol_en), 8'h01);
      req("b1b.d2", 2'b10, 1'b1);
      req("b1b.d3", 2'b11, 1'b1);
      req_end("b1b");

      // Byte E4: dibits 11 10 01 00
      push(8'hE4);
      tick();
      preamble("be4");
      sfd("be4");
      req("be4.d0", 2'b11, 1'b1);
      req("be4.d1", 2'b10, 1'b1);
      req("be4.d2", 2'b01, 1'b1);
      req("be4.d3", 2'b00, 1'b1);
      req_end("be4");

      // Full FIFO: six bytes offered, four accepted until pops free space
      push(8'h1E); push(8'h2D); push(8'h3C); push(8'h4B); push(8'h5A); push(8'h69);
      for (int i = 0; i < 4; i++) tick();
      chk("full.level", 8'(fifo_level), 8'h04);
      chk("full.ready", 8'(s_ready), 8'h00);
      tick();
      tick();
      chk("full.level_hold", 8'(fifo_level), 8'h04);
      chk("full.pending", 8'(feed_q.size()), 8'h02);
      preamble("full");
      sfd("full");
      req("full.a1d0", 2'b00, 1'b1);
      chk("full.pop_no_push", 8'(fifo_level), 8'h03);
      chk("full.ready_after_pop", 8'(s_ready), 8'h01);
      payload_byte("full.a1", 8'h1E, 1);
      payload_byte("full.a2", 8'h2D, 0);
      payload_byte("full.a3", 8'h3C, 0);
      payload_byte("full.a4", 8'h4B, 0);
      payload_byte("full.a5", 8'h5A, 0);
      payload_byte("full.a6", 8'h69, 0);
      chk("full.drained", 8'(fifo_level), 8'h00);
      chk("full.queue", 8'(feed_q.size()), 8'h00);
      req_end("full");

      // Refill mid-byte: frame continues without frame_done
      push(8'h9C);
      tick();
      preamble("ur");
      sfd("ur");
      req("ur.d0", 2'b10, 1'b1);
      req("ur.d1", 2'b01, 1'b1);
      push(8'h3A);
      tick();
      chk("ur.level", 8'(fifo_level), 8'h01);
      req("ur.d2", 2'b11, 1'b1);
      req("ur.d3", 2'b00, 1'b1);
      req("ur.e0", 2'b00, 1'b1);
      req("ur.e1", 2'b11, 1'b1);
      req("ur.e2", 2'b10, 1'b1);
      req("ur.e3", 2'b10, 1'b1);
      req_end("ur");

      // Refill after frame end: new full frame
      push(8'h55);
      tick();
      preamble("late1");
      sfd("late1");
      payload_byte("late1.p", 8'h55, 0);
      req_end("late1");
      push(8'hAA);
      tick();
      preamble("late2");
      sfd("late2");
      payload_byte("late2.p", 8'hAA, 0);
      req_end("late2");

      // Reset during SFD with three bytes buffered
      push(8'h11); push(8'h22); push(8'h33);
      tick(); tick(); tick();
      chk("mid.level", 8'(fifo_level), 8'h03);
      preamble("mid");
      req("mid.sfd0", 2'b11, 1'b1);
      req("mid.sfd1", 2'b01, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid.rst_level", 8'(fifo_level), 8'h00);
      chk("mid.rst_en", 8'(symbol_en), 8'h00);
      chk("mid.rst_sym", 8'(symbol_out), 8'h00);
      chk("mid.rst_busy", 8'(busy), 8'h00);
      chk("mid.rst_fd", 8'(frame_done), 8'h00);
      chk("mid.rst_ready", 8'(s_ready), 8'h01);
      req("mid.idle", 2'b00, 1'b0);
      push(8'h0F);
      tick();
      preamble("post");
      sfd("post");
      payload_byte("post.p", 8'h0F, 0);
      req_end("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
